// File: rtl/aether_pifo_pkg.sv
// Shared types and default widths for the Aether PIFO client adapters.
package aether_pifo_pkg;

  localparam int unsigned PTW = 16;
  localparam int unsigned MTW = 32;
  localparam int unsigned DW  = MTW + PTW;

  typedef struct packed {
    logic [MTW-1:0] meta;
    logic [PTW-1:0] prio;
  } entry_t;

  typedef enum logic {
    GNT_PUSH = 1'b0,
    GNT_POP  = 1'b1
  } grant_t;

endpackage

// File: rtl/aether_egr_fifo.sv
// Output FIFO for the PIFO egress adapter; a read frees its slot in the same
// cycle, so a write is accepted at full whenever a read accompanies it.
module aether_egr_fifo #(
  parameter int unsigned DW         = 48,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic                          wr_en,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          rd_en,
  output logic [DW-1:0]                 rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign rd_ok   = rd_en && (count != '0);
  assign wr_ok   = wr_en && ((count != CW'(FIFO_DEPTH)) || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aether_pifo_egress.sv
// Push/pop stream adapter onto the PIFO single-op command port with
// credit-protected pop prefetch. Optional AETHER_EGR_STATS_EN adds counters.
module aether_pifo_egress
  import aether_pifo_pkg::*;
#(
  parameter int unsigned PTW        = aether_pifo_pkg::PTW,
  parameter int unsigned MTW        = aether_pifo_pkg::MTW,
  parameter int unsigned POP_LAT    = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CAP        = 87380,
  parameter int unsigned CNT_W      = 17
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
`ifdef AETHER_EGR_STATS_EN
  output logic [31:0]          o_stat_push_cnt,
  output logic [31:0]          o_stat_pop_cnt,
  output logic [31:0]          o_stat_bp_cnt,
`endif
  input  logic                 s_push_valid,
  output logic                 s_push_ready,
  input  logic [MTW+PTW-1:0]   s_push_data,
  output logic                 m_pop_valid,
  input  logic                 m_pop_ready,
  output logic [MTW+PTW-1:0]   m_pop_data,
  output logic                 o_pifo_push,
  output logic                 o_pifo_pop,
  output logic [MTW+PTW-1:0]   o_pifo_data,
  input  logic [MTW+PTW-1:0]   i_pifo_data,
  output logic [CNT_W-1:0]     o_occupancy,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]      occupancy;
  logic [POP_LAT-1:0]    inflight;
  grant_t                last_grant;
  logic [CW-1:0]         fifo_count;
  logic [MTW+PTW-1:0]    fifo_head;
  logic                  fifo_rd;
  logic [31:0]           outstanding;
  logic                  push_elig;
  logic                  pop_elig;
  logic                  grant_push;
  logic                  grant_pop;

  // Every pop already issued (command register plus pipeline) holds a FIFO slot.
  always_comb begin
    outstanding = 32'(fifo_count) + 32'(o_pifo_pop);
    for (int unsigned i = 0; i < POP_LAT; i++) begin
      outstanding = outstanding + 32'(inflight[i]);
    end
  end

  assign push_elig  = s_push_valid && (32'(occupancy) < CAP);
  assign pop_elig   = (occupancy != '0) && (outstanding < FIFO_DEPTH);
  assign grant_push = push_elig && (!pop_elig || (last_grant == GNT_POP));
  assign grant_pop  = pop_elig && !grant_push;

  assign s_push_ready = grant_push;
  assign o_occupancy  = occupancy;
  assign o_empty      = (occupancy == '0);
  assign o_full       = (32'(occupancy) == CAP);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_pifo_push <= 1'b0;
      o_pifo_pop  <= 1'b0;
      o_pifo_data <= '0;
      occupancy   <= '0;
      inflight    <= '0;
      last_grant  <= GNT_PUSH;
    end else begin
      o_pifo_push <= grant_push;
      o_pifo_pop  <= grant_pop;
      if (grant_push) begin
        o_pifo_data <= s_push_data;
        occupancy   <= occupancy + CNT_W'(1);
        last_grant  <= GNT_PUSH;
      end else if (grant_pop) begin
        occupancy   <= occupancy - CNT_W'(1);
        last_grant  <= GNT_POP;
      end
      // Tail bit lines up with the cycle the PIFO presents the pop result.
      inflight[0] <= o_pifo_pop;
      for (int unsigned i = 1; i < POP_LAT; i++) begin
        inflight[i] <= inflight[i-1];
      end
    end
  end

  assign fifo_rd     = m_pop_valid && m_pop_ready;
  assign m_pop_valid = (fifo_count != '0);
  assign m_pop_data  = m_pop_valid ? fifo_head : '0;

  aether_egr_fifo #(
    .DW         (MTW + PTW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .wr_en    (inflight[POP_LAT-1]),
    .wr_data  (i_pifo_data),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_head),
    .count    (fifo_count)
  );

`ifdef AETHER_EGR_STATS_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_stat_push_cnt <= '0;
      o_stat_pop_cnt  <= '0;
      o_stat_bp_cnt   <= '0;
    end else begin
      if (grant_push)                  o_stat_push_cnt <= o_stat_push_cnt + 32'd1;
      if (fifo_rd)                     o_stat_pop_cnt  <= o_stat_pop_cnt + 32'd1;
      if (s_push_valid && !grant_push) o_stat_bp_cnt   <= o_stat_bp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aether_pifo_egress.sv
// Randomised bench for aether_pifo_egress against a queue-based adapter model
// and a behavioural PIFO environment (min-priority, fixed pop latency).
module tb_aether_pifo_egress;

  localparam int unsigned PTW        = 16;
  localparam int unsigned MTW        = 32;
  localparam int unsigned DW         = 48;
  localparam int unsigned POP_LAT    = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CAP        = 16;
  localparam int unsigned CNT_W      = 17;

  logic             i_clk;
  logic             i_arst_n;
  logic             s_push_valid;
  logic             s_push_ready;
  logic [DW-1:0]    s_push_data;
  logic             m_pop_valid;
  logic             m_pop_ready;
  logic [DW-1:0]    m_pop_data;
  logic             o_pifo_push;
  logic             o_pifo_pop;
  logic [DW-1:0]    o_pifo_data;
  logic [DW-1:0]    i_pifo_data;
  logic [CNT_W-1:0] o_occupancy;
  logic             o_empty;
  logic             o_full;
`ifdef AETHER_EGR_STATS_EN
  logic [31:0]      o_stat_push_cnt;
  logic [31:0]      o_stat_pop_cnt;
  logic [31:0]      o_stat_bp_cnt;
`endif

  aether_pifo_egress #(
    .PTW        (PTW),
    .MTW        (MTW),
    .POP_LAT    (POP_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CAP        (CAP),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk           (i_clk),
    .i_arst_n        (i_arst_n),
`ifdef AETHER_EGR_STATS_EN
    .o_stat_push_cnt (o_stat_push_cnt),
    .o_stat_pop_cnt  (o_stat_pop_cnt),
    .o_stat_bp_cnt   (o_stat_bp_cnt),
`endif
    .s_push_valid    (s_push_valid),
    .s_push_ready    (s_push_ready),
    .s_push_data     (s_push_data),
    .m_pop_valid     (m_pop_valid),
    .m_pop_ready     (m_pop_ready),
    .m_pop_data      (m_pop_data),
    .o_pifo_push     (o_pifo_push),
    .o_pifo_pop      (o_pifo_pop),
    .o_pifo_data     (o_pifo_data),
    .i_pifo_data     (i_pifo_data),
    .o_occupancy     (o_occupancy),
    .o_empty         (o_empty),
    .o_full          (o_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Adapter reference state
  int            cyc;
  int unsigned   m_occ;
  bit            m_last_pop;
  bit            m_prev_push;
  bit            m_prev_pop;
  logic [DW-1:0] m_pifo_data;
  logic [DW-1:0] m_fifo[$];
  int            m_due[$];
  int unsigned   st_push, st_pop, st_bp;

  // PIFO environment
  logic [DW-1:0] env_store[$];
  logic [DW-1:0] env_ret[$];
  int            env_due[$];

  // Stimulus control and phase observations
  logic [DW-1:0] push_q[$];
  int unsigned   push_prob, ready_prob, ready_pulse;
  int            n_pop_cmd, n_push_cmd, n_deq, first_pop, first_val;
  logic [15:0]   deq_log[$];
  logic [15:0]   t1_exp[3];

  function automatic logic [DW-1:0] rand_entry();
    logic [31:0] meta;
    logic [15:0] prio;
    meta = $urandom();
    prio = 16'($urandom_range(0, 15));
    return {meta, prio};
  endfunction

  function automatic logic [DW-1:0] env_take();
    int          best;
    logic [DW-1:0] a, b;
    logic [DW-1:0] res;
    best = 0;
    for (int i = 1; i < env_store.size(); i++) begin
      a = env_store[i];
      b = env_store[best];
      if (a[PTW-1:0] < b[PTW-1:0]) best = i;
    end
    res = env_store[best];
    env_store.delete(best);
    return res;
  endfunction

  task automatic clear_obs();
    n_pop_cmd = 0; n_push_cmd = 0; n_deq = 0;
    first_pop = -1; first_val = -1;
    deq_log.delete();
  endtask

  task automatic cycle();
    bit pe, qe, pg, qg;
    int unsigned outst;
    @(negedge i_clk);
    outst = m_fifo.size() + m_due.size();
    pe = s_push_valid && (m_occ < CAP);
    qe = (m_occ > 0) && (outst < FIFO_DEPTH);
    pg = pe && (!qe || m_last_pop);
    qg = qe && !pg;

    chk("push_ready", 64'(s_push_ready), 64'(pg));
    chk("pifo_push", 64'(o_pifo_push), 64'(m_prev_push));
    chk("pifo_pop", 64'(o_pifo_pop), 64'(m_prev_pop));
    chk("cmd_excl", 64'(o_pifo_push && o_pifo_pop), 64'(0));
    chk("pifo_data", 64'(o_pifo_data), 64'(m_pifo_data));
    chk("occupancy", 64'(o_occupancy), 64'(m_occ));
    chk("empty", 64'(o_empty), 64'(m_occ == 0));
    chk("full", 64'(o_full), 64'(m_occ == CAP));
    chk("pop_valid", 64'(m_pop_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("pop_data", 64'(m_pop_data), 64'(m_fifo[0]));
`ifdef AETHER_EGR_STATS_EN
    chk("stat_push", 64'(o_stat_push_cnt), 64'(st_push));
    chk("stat_pop", 64'(o_stat_pop_cnt), 64'(st_pop));
    chk("stat_bp", 64'(o_stat_bp_cnt), 64'(st_bp));
`endif

    if (o_pifo_pop) n_pop_cmd++;
    if (o_pifo_push) n_push_cmd++;
    if (o_pifo_pop && first_pop < 0) first_pop = cyc;
    if (m_pop_valid && first_val < 0) first_val = cyc;
    if (m_pop_valid && m_pop_ready) begin
      n_deq++;
      deq_log.push_back(m_pop_data[PTW-1:0]);
    end

    if ((m_fifo.size() != 0) && m_pop_ready) begin
      void'(m_fifo.pop_front());
      st_pop++;
    end
    if ((m_due.size() != 0) && (m_due[0] == cyc)) begin
      void'(m_due.pop_front());
      m_fifo.push_back(i_pifo_data);
    end
    if (s_push_valid && !pg) st_bp++;
    if (pg) begin
      m_occ++;
      m_last_pop = 1'b0;
      m_pifo_data = s_push_data;
      st_push++;
      if (push_q.size() != 0) void'(push_q.pop_front());
    end else if (qg) begin
      m_occ--;
      m_last_pop = 1'b1;
      m_due.push_back(cyc + 1 + int'(POP_LAT));
    end
    m_prev_push = pg;
    m_prev_pop  = qg;

    @(posedge i_clk);
    if (o_pifo_push) env_store.push_back(o_pifo_data);
    if (o_pifo_pop) begin
      chk("pifo_pop_nonempty", 64'(env_store.size() != 0), 64'(1));
      if (env_store.size() != 0) begin
        env_ret.push_back(env_take());
        env_due.push_back(cyc + int'(POP_LAT));
      end
    end
    cyc++;
    #1;
    if ((env_due.size() != 0) && (env_due[0] == cyc)) begin
      i_pifo_data = env_ret.pop_front();
      void'(env_due.pop_front());
    end else begin
      i_pifo_data = {$urandom(), 16'($urandom())};
    end
    if ((push_prob != 0) && (push_q.size() == 0) && ($urandom_range(99) < push_prob))
      push_q.push_back(rand_entry());
    s_push_valid = (push_q.size() != 0);
    s_push_data  = (push_q.size() != 0) ? push_q[0] : rand_entry();
    m_pop_ready  = (ready_pulse != 0) || ($urandom_range(99) < ready_prob);
    if (ready_pulse != 0) ready_pulse--;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_arst_n     = 1'b0;
    s_push_valid = 1'b0;
    m_pop_ready  = 1'b0;
    push_q.delete();
    push_prob = 0; ready_prob = 0; ready_pulse = 0;
    #1;
    chk("rst_pifo_push", 64'(o_pifo_push), 64'(0));
    chk("rst_pifo_pop", 64'(o_pifo_pop), 64'(0));
    chk("rst_pifo_data", 64'(o_pifo_data), 64'(0));
    chk("rst_pop_valid", 64'(m_pop_valid), 64'(0));
    chk("rst_pop_data", 64'(m_pop_data), 64'(0));
    chk("rst_push_ready", 64'(s_push_ready), 64'(0));
    chk("rst_occ", 64'(o_occupancy), 64'(0));
    chk("rst_empty", 64'(o_empty), 64'(1));
    chk("rst_full", 64'(o_full), 64'(0));
`ifdef AETHER_EGR_STATS_EN
    chk("rst_stat_push", 64'(o_stat_push_cnt), 64'(0));
    chk("rst_stat_pop", 64'(o_stat_pop_cnt), 64'(0));
    chk("rst_stat_bp", 64'(o_stat_bp_cnt), 64'(0));
`endif
    m_occ = 0; m_last_pop = 1'b0; m_prev_push = 1'b0; m_prev_pop = 1'b0;
    m_pifo_data = '0;
    m_fifo.delete(); m_due.delete();
    env_store.delete(); env_ret.delete(); env_due.delete();
    st_push = 0; st_pop = 0; st_bp = 0;
    i_pifo_data = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    i_arst_n = 1'b1; s_push_valid = 1'b0; s_push_data = '0;
    m_pop_ready = 1'b0; i_pifo_data = '0;
    t1_exp[0] = 16'd5; t1_exp[1] = 16'd1; t1_exp[2] = 16'd9;

    // Three pushes, consumer always ready: push/pop alternate, order 5,1,9.
    do_reset();
    clear_obs();
    push_q.push_back({32'($urandom()), 16'd5});
    push_q.push_back({32'($urandom()), 16'd1});
    push_q.push_back({32'($urandom()), 16'd9});
    ready_prob = 100;
    run(30);
    chk("t1_push_cmds", 64'(n_push_cmd), 64'(3));
    chk("t1_pop_cmds", 64'(n_pop_cmd), 64'(3));
    chk("t1_latency", 64'(first_val - first_pop), 64'(5));
    chk("t1_deq_n", 64'(deq_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < deq_log.size(); i++)
      chk("t1_order", 64'(deq_log[i]), 64'(t1_exp[i]));

    // Continuous push stream with free credits: commands alternate.
    do_reset();
    clear_obs();
    push_prob = 100; ready_prob = 100;
    run(40);
    chk("alt_balance", 64'((n_push_cmd - n_pop_cmd) inside {0, 1}), 64'(1));

    // Consumer stalled: prefetch stops at FIFO_DEPTH, pushes fill to CAP.
    do_reset();
    clear_obs();
    for (int i = 0; i < 30; i++) push_q.push_back(rand_entry());
    run(80);
    chk("stall_pops", 64'(n_pop_cmd), 64'(FIFO_DEPTH));
    chk("full_pushes", 64'(n_push_cmd), 64'(CAP + FIFO_DEPTH));
    chk("full_flag", 64'(o_full), 64'(1));
    chk("full_ready", 64'(s_push_ready), 64'(0));
    chk("full_occ", 64'(o_occupancy), 64'(CAP));
    clear_obs();
    ready_pulse = 1;
    run(20);
    chk("one_deq", 64'(n_deq), 64'(1));
    chk("one_pop", 64'(n_pop_cmd), 64'(1));
    chk("one_push", 64'(n_push_cmd), 64'(1));

    // Reset with pops in flight.
    do_reset();
    clear_obs();
    for (int i = 0; i < 6; i++) push_q.push_back(rand_entry());
    for (int i = 0; i < 40 && n_pop_cmd < 3; i++) cycle();
    chk("inflight_reached", 64'(n_pop_cmd >= 3), 64'(1));
    do_reset();
    clear_obs();
    run(12);
    chk("post_rst_occ", 64'(o_occupancy), 64'(0));
    chk("post_rst_deq", 64'(n_deq), 64'(0));

    // Randomised soak with a mid-run reset, then drain.
    do_reset();
    push_prob = 50; ready_prob = 60;
    run(1500);
    push_prob = 80; ready_prob = 20;
    run(800);
    do_reset();
    push_prob = 30; ready_prob = 90;
    run(800);
    push_prob = 0; ready_prob = 100;
    run(80);
    chk("drain_occ", 64'(o_occupancy), 64'(0));
    chk("drain_valid", 64'(m_pop_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
